im_load_ctrl: RTL and testbench
===============================

Name: im_load_ctrl

Overview:
Sequences loading of a program image from the UART byte stream into the instruction memory, replacing the free-running byte packer. It parses a framed image: sync byte, 16-bit word count, big-endian payload words, then an 8-bit checksum. It drives the memory write port and holds the CPU in reset while a load is in progress. It reports done/error status to the board-level logic (LEDs, top FSM).

Parameters:
SIZE, 1024, instruction memory depth in 32-bit words; maximum legal word count.
SYNC, 8'hA5, frame start byte.
TIMEOUT, 1000000, maximum clk cycles between bytes after sync before aborting with error.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
load_req  input  1  single-cycle pulse; starts a load (accepted in IDLE or ERR only)
abort  input  1  single-cycle pulse; forces ERR from any busy state
uart_v  input  1  received byte valid, single-cycle
uart_d  input  8  received byte
im_wa  output  32  memory write word address
im_wd  output  32  memory write data
im_we  output  1  memory write enable, single-cycle pulse
cpu_hold  output  1  1 = CPU held in reset
busy  output  1  load in progress (state not IDLE/ERR)
done  output  1  single-cycle pulse on successful completion
err  output  1  sticky error flag
words_loaded  output  16  words written so far in the current load

Behaviour:
- Reset (async, rstn=0): state IDLE; im_wa=0, im_wd=0, im_we=0, cpu_hold=0, busy=0, done=0, err=0, words_loaded=0; internal len, byte counter, checksum and timeout counter cleared.
- States: IDLE, SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE: uart_v ignored. load_req -> SYNC; cpu_hold=1, im_wa=0, words_loaded=0, checksum=0, err=0.
- SYNC: bytes != SYNC are discarded. Byte == SYNC -> LEN_HI. There is no timeout in SYNC.
- LEN_HI/LEN_LO: capture len[15:8], then len[7:0]. On LEN_LO, len==0 or len>SIZE -> ERR; otherwise -> DATA.
- DATA: bytes fill im_wd MSB first: byte0 -> [31:24], through byte3 -> [7:0]. Every payload byte is added to checksum mod 256. On the cycle after the 4th byte, im_we=1 for exactly one cycle with im_wa = current word index. In the following cycle im_wa increments and words_loaded increments. When words_loaded reaches len -> CSUM.
- im_wd and im_wa are stable for the whole im_we cycle. No write is issued for a partial word.
- A uart_v coinciding with the im_we cycle is accepted as byte0 of the next word. The UART byte rate guarantees at least 2 idle cycles between bytes, but the RTL must not drop such a byte.
- CSUM: received byte == checksum -> DONE; otherwise -> ERR.
- DONE: done=1 for one cycle, cpu_hold=0, busy=0 -> IDLE.
- ERR: err=1 (sticky), cpu_hold stays 1, uart_v ignored. load_req -> SYNC and clears err. err is cleared only by reset or load_req.
- Timeout: in LEN_HI, LEN_LO, DATA and CSUM, a counter reloads on each uart_v. If it reaches TIMEOUT with no byte -> ERR.
- abort in any state except IDLE/ERR -> ERR on the next clock; abort in IDLE is ignored.
- Simultaneous abort and uart_v: abort wins and the byte is discarded.
- load_req while busy is ignored.
- Reset mid-load: all state is cleared immediately; cpu_hold=0; memory contents already written are left as-is.
- Width rules: words_loaded and len are 16 bits; im_wa is zero-extended from the word index; checksum is 8 bits and wraps.

Test Plan:
- Nominal: load_req, then A5 00 02 | 00 00 00 13 | 12 34 56 78 | 0x27 -> two im_we pulses, (wa0, 0x00000013) then (wa1, 0x12345678); done pulse; cpu_hold 1 -> 0; err=0.
- Junk before sync: 00 FF 13 A5 00 01 DE AD BE EF 0x38 -> single write (0, 0xDEADBEEF); done; junk bytes produce no writes.
- Bad checksum: nominal frame with last byte 0x28 -> both writes occur, then err=1, cpu_hold=1, no done. A following load_req clears err and state is SYNC.
- Length bounds: A5 00 00, and with SIZE=1024 A5 04 01 -> ERR right after the LEN_LO byte, zero writes. A5 04 00 is accepted.
- Timeout/abort: with TIMEOUT=100, stop after 2 payload bytes -> ERR 100 cycles after the last byte, no write. Separately, abort mid-DATA -> ERR next clock.
- Async reset: drop rstn mid-DATA -> all outputs at reset values within the same cycle; a fresh load_req plus full frame then completes normally.

Source files
------------

// File: rtl/im_load_ctrl_if.sv
// Bundle for the image loader. It carries the host-side controls, the UART
// byte stream, the instruction-memory write port and the status outputs.
// The slave modport is the loader's view. The master modport is the view of
// the board logic or testbench that drives it.
interface im_load_ctrl_if;
  logic        load_req;
  logic        abort;
  logic        uart_v;
  logic [7:0]  uart_d;
  logic [31:0] im_wa;
  logic [31:0] im_wd;
  logic        im_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  modport slave (
    input  load_req, abort, uart_v, uart_d,
    output im_wa, im_wd, im_we, cpu_hold, busy, done, err, words_loaded
  );

  modport master (
    output load_req, abort, uart_v, uart_d,
    input  im_wa, im_wd, im_we, cpu_hold, busy, done, err, words_loaded
  );
endinterface

// File: rtl/im_load_ctrl.sv
// Program-image loader.
// It parses the UART frame: sync byte, 16-bit word count, big-endian words,
// and an 8-bit additive checksum. It writes the instruction memory one word
// at a time and holds the CPU in reset until the image is complete.
module im_load_ctrl #(
  parameter int         SIZE    = 1024,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rstn,
  im_load_ctrl_if.slave bus
);
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]     SIZE_W   = 17'(SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        state_reg, state_next;
  logic [15:0]   len_reg;
  logic [15:0]   words_loaded_reg;
  logic [1:0]    byte_cnt_reg;
  logic [7:0]    csum_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [31:0]   im_wd_reg;
  logic          im_we_reg;
  logic          busy_reg, cpu_hold_reg, done_reg, err_reg;

  logic          byte_v;      // byte that survives a simultaneous abort
  logic          start;       // accepted load request
  logic          timed;       // state in which the inter-byte timer runs
  logic          tmo_hit;
  logic          last_word;
  logic          final_we;    // write cycle of the last payload word
  logic          data_take;   // byte goes into the payload shifter
  logic [15:0]   len_full;
  logic          len_bad;

  assign byte_v    = bus.uart_v && !bus.abort;
  assign start     = bus.load_req && (state_reg == S_IDLE || state_reg == S_ERR);
  assign timed     = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                     (state_reg == S_DATA)   || (state_reg == S_CSUM);
  assign tmo_hit   = timed && !bus.uart_v && (tmo_cnt_reg == TMO_LAST);
  assign last_word = (words_loaded_reg + 16'd1) == len_reg;
  assign final_we  = (state_reg == S_DATA) && im_we_reg && last_word;
  // A byte that lands on the final write cycle is already the checksum.
  assign data_take = (state_reg == S_DATA) && byte_v && !final_we;
  assign len_full  = {len_reg[15:8], bus.uart_d};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > SIZE_W);

  // Next-state logic. Timeout and abort override the normal progression.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_SYNC;
      S_SYNC:   if (byte_v && bus.uart_d == SYNC) state_next = S_LEN_HI;
      S_LEN_HI: if (byte_v) state_next = S_LEN_LO;
      S_LEN_LO: if (byte_v) state_next = len_bad ? S_ERR : S_DATA;
      S_DATA: begin
        if (final_we) begin
          if (byte_v) state_next = (bus.uart_d == csum_reg) ? S_DONE : S_ERR;
          else        state_next = S_CSUM;
        end
      end
      S_CSUM:   if (byte_v) state_next = (bus.uart_d == csum_reg) ? S_DONE : S_ERR;
      S_DONE:   state_next = S_IDLE;
      S_ERR:    if (start) state_next = S_SYNC;
      default:  state_next = S_IDLE;
    endcase
    if (tmo_hit) state_next = S_ERR;
    if (bus.abort && state_reg != S_IDLE && state_reg != S_ERR) state_next = S_ERR;
  end

  // State register, with the status outputs registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= S_IDLE;
      busy_reg     <= 1'b0;
      cpu_hold_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= (state_next != S_IDLE) && (state_next != S_ERR) &&
                      (state_next != S_DONE);
      cpu_hold_reg <= (state_next != S_IDLE) && (state_next != S_DONE);
      done_reg     <= (state_next == S_DONE);
      err_reg      <= (state_next == S_ERR);
    end
  end

  // Datapath: length capture, payload shifter, checksum, write strobe and inter-byte timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_reg          <= '0;
      words_loaded_reg <= '0;
      byte_cnt_reg     <= '0;
      csum_reg         <= '0;
      tmo_cnt_reg      <= '0;
      im_wd_reg        <= '0;
      im_we_reg        <= 1'b0;
    end else begin
      im_we_reg <= 1'b0;
      if (im_we_reg) words_loaded_reg <= words_loaded_reg + 16'd1;
      if (start) begin
        words_loaded_reg <= '0;
        byte_cnt_reg     <= '0;
        csum_reg         <= '0;
      end
      if (state_reg == S_LEN_HI && byte_v) len_reg[15:8] <= bus.uart_d;
      if (state_reg == S_LEN_LO && byte_v) len_reg[7:0]  <= bus.uart_d;
      if (data_take) begin
        im_wd_reg    <= {im_wd_reg[23:0], bus.uart_d};
        csum_reg     <= csum_reg + bus.uart_d;
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        if (byte_cnt_reg == 2'd3) im_we_reg <= 1'b1;
      end
      if (!timed || bus.uart_v) tmo_cnt_reg <= '0;
      else                      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign bus.im_wa        = {16'd0, words_loaded_reg};
  assign bus.im_wd        = im_wd_reg;
  assign bus.im_we        = im_we_reg;
  assign bus.cpu_hold     = cpu_hold_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
  assign bus.err          = err_reg;
  assign bus.words_loaded = words_loaded_reg;
endmodule

// File: tb/tb_im_load_ctrl.sv
// Directed bench for the image loader. It sends framed images over the byte
// port, logs every memory write and done pulse, and compares each result
// against hand-computed values.
module tb_im_load_ctrl;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   done_cnt = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  frame_q[$];

  im_load_ctrl_if bus();

  im_load_ctrl #(.SIZE(1024), .SYNC(8'hA5), .TIMEOUT(100)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Write and done logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.im_we) begin
        wa_q.push_back(bus.im_wa);
        wd_q.push_back(bus.im_wd);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [31:0] wa_at(input int i);
    if (i < wa_q.size()) return wa_q[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    if (i < wd_q.size()) return wd_q[i];
    return 32'hxxxxxxxx;
  endfunction

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.uart_v = 1'b1;
    bus.uart_d = b;
    @(negedge clk);
    bus.uart_v = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    foreach (frame_q[i]) send_byte(frame_q[i], gap);
  endtask

  task automatic start_load();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
  endtask

  initial begin
    bus.load_req = 1'b0;
    bus.abort    = 1'b0;
    bus.uart_v   = 1'b0;
    bus.uart_d   = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values.
    check_vec("rst_busy", 32'(bus.busy), 32'd0);
    check_vec("rst_hold", 32'(bus.cpu_hold), 32'd0);
    check_vec("rst_err", 32'(bus.err), 32'd0);
    check_vec("rst_done", 32'(bus.done), 32'd0);
    check_vec("rst_we", 32'(bus.im_we), 32'd0);
    check_vec("rst_words", 32'(bus.words_loaded), 32'd0);
    check_vec("rst_wa", bus.im_wa, 32'd0);
    check_vec("rst_wd", bus.im_wd, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Bytes are ignored in IDLE.
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(2);
    check_vec("idle_busy", 32'(bus.busy), 32'd0);
    check_vec("idle_writes", 32'(wa_q.size()), 32'd0);

    // Nominal two-word frame, once with spaced bytes and once back-to-back.
    for (int g = 2; g >= 0; g -= 2) begin
      start_load();
      check_vec("nom_hold_on", 32'(bus.cpu_hold), 32'd1);
      check_vec("nom_busy_on", 32'(bus.busy), 32'd1);
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h27};
      send_frame(g);
      repeat (3) @(negedge clk);
      check_vec("nom_nwr", 32'(wa_q.size()), 32'd2);
      check_vec("nom_wa0", wa_at(0), 32'd0);
      check_vec("nom_wd0", wd_at(0), 32'h00000013);
      check_vec("nom_wa1", wa_at(1), 32'd1);
      check_vec("nom_wd1", wd_at(1), 32'h12345678);
      check_vec("nom_done", 32'(done_cnt), 32'd1);
      check_vec("nom_err", 32'(bus.err), 32'd0);
      check_vec("nom_hold_off", 32'(bus.cpu_hold), 32'd0);
      check_vec("nom_busy_off", 32'(bus.busy), 32'd0);
      check_vec("nom_words", 32'(bus.words_loaded), 32'd2);
    end

    // Junk ahead of the sync byte.
    start_load();
    frame_q = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h01,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
    send_frame(0);
    repeat (3) @(negedge clk);
    check_vec("junk_nwr", 32'(wa_q.size()), 32'd1);
    check_vec("junk_wa0", wa_at(0), 32'd0);
    check_vec("junk_wd0", wd_at(0), 32'hDEADBEEF);
    check_vec("junk_done", 32'(done_cnt), 32'd1);

    // Bad checksum.
    start_load();
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13,
                8'h12, 8'h34, 8'h56, 8'h78, 8'h28};
    send_frame(2);
    check_vec("bad_nwr", 32'(wa_q.size()), 32'd2);
    check_vec("bad_wd1", wd_at(1), 32'h12345678);
    check_vec("bad_err", 32'(bus.err), 32'd1);
    check_vec("bad_hold", 32'(bus.cpu_hold), 32'd1);
    check_vec("bad_done", 32'(done_cnt), 32'd0);
    start_load();
    check_vec("rel_err", 32'(bus.err), 32'd0);
    check_vec("rel_busy", 32'(bus.busy), 32'd1);
    check_vec("rel_hold", 32'(bus.cpu_hold), 32'd1);

    // Length bounds: zero, SIZE+1, then SIZE accepted.
    frame_q = '{8'hA5, 8'h00, 8'h00};
    send_frame(2);
    check_vec("len0_err", 32'(bus.err), 32'd1);
    start_load();
    frame_q = '{8'hA5, 8'h04, 8'h01};
    send_frame(2);
    check_vec("len_big_err", 32'(bus.err), 32'd1);
    check_vec("len_nwr", 32'(wa_q.size()), 32'd0);
    start_load();
    frame_q = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02};
    send_frame(2);
    check_vec("len_max_err", 32'(bus.err), 32'd0);
    check_vec("len_max_busy", 32'(bus.busy), 32'd1);

    // Abort mid-DATA, with a coincident byte that must be discarded.
    bus.abort  = 1'b1;
    bus.uart_v = 1'b1;
    bus.uart_d = 8'h03;
    @(negedge clk);
    bus.abort  = 1'b0;
    bus.uart_v = 1'b0;
    check_vec("abort_err", 32'(bus.err), 32'd1);
    check_vec("abort_busy", 32'(bus.busy), 32'd0);
    send_byte(8'h04, 2);
    check_vec("abort_nwr", 32'(wa_q.size()), 32'd0);

    // Inter-byte timeout after two payload bytes.
    start_load();
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB};
    send_frame(0);
    repeat (99) @(negedge clk);
    check_vec("tmo_early", 32'(bus.err), 32'd0);
    @(negedge clk);
    check_vec("tmo_err", 32'(bus.err), 32'd1);
    check_vec("tmo_nwr", 32'(wa_q.size()), 32'd0);

    // Asynchronous reset mid-DATA, then a clean reload.
    start_load();
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    send_frame(2);
    #2 rstn = 1'b0;
    #1;
    check_vec("arst_hold", 32'(bus.cpu_hold), 32'd0);
    check_vec("arst_busy", 32'(bus.busy), 32'd0);
    check_vec("arst_words", 32'(bus.words_loaded), 32'd0);
    check_vec("arst_wd", bus.im_wd, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_load();
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h40};
    send_frame(2);
    repeat (3) @(negedge clk);
    check_vec("post_nwr", 32'(wa_q.size()), 32'd1);
    check_vec("post_wa0", wa_at(0), 32'd0);
    check_vec("post_wd0", wd_at(0), 32'hCAFEBABE);
    check_vec("post_done", 32'(done_cnt), 32'd1);
    check_vec("post_hold", 32'(bus.cpu_hold), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
